// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int DEFAULT_BAUD_DIV = 434;
    localparam int DATA_BITS        = 8;
    localparam int BIT_W            = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            meta  <= rxd;
            rxd_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive sequencer: start detection, mid-bit sampling, shift-register control,
// latch strobe, valid/ack handshake and sticky framing/overrun flags.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic sh_en,
    output logic sh_rxd,
    output logic rd_latch,
    output logic rx_valid,
    input  logic rx_ack,
    output logic frame_err,
    output logic overrun,
    input  logic err_clr,
    output logic busy
);

    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic             rxd_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bitcnt;
    logic             cnt_clr;
    logic             bit_clr;
    logic             sh_pulse;
    logic             latch_pulse;
    logic             ferr_set;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
        end else begin
            state <= state_n;
            // Counter restarts on every state entry and at each data-bit boundary.
            if (state_n != state || cnt_clr)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (bit_clr)
                bitcnt <= '0;
            else if (sh_pulse)
                bitcnt <= bitcnt + 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_clr     = 1'b0;
        bit_clr     = 1'b0;
        sh_pulse    = 1'b0;
        latch_pulse = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s)
                    state_n = START;
            end
            START: begin
                if (cnt == CNT_MID) begin
                    bit_clr = 1'b1;
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    sh_pulse = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bitcnt == BIT_LAST)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    if (rxd_s) begin
                        latch_pulse = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_en     <= 1'b0;
            sh_rxd    <= 1'b0;
            rd_latch  <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sh_en    <= sh_pulse;
            rd_latch <= latch_pulse;
            if (sh_pulse)
                sh_rxd <= rxd_s;
            // A new byte wins over an ack in the same cycle; the ack retires the old byte.
            if (rd_latch)
                rx_valid <= 1'b1;
            else if (rx_ack)
                rx_valid <= 1'b0;
            if (ferr_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
            if (rd_latch && rx_valid && !rx_ack)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at BAUD_DIV = 8: framing, glitch rejection, errors, overrun, reset.
module tb_uart_rx_ctrl;

    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst, rxd, rx_ack, err_clr;
    logic sh_en, sh_rxd, rd_latch, rx_valid, frame_err, overrun, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_latch = 0;
    bit   q_bits[$];
    int   q_t[$];

    uart_rx_ctrl #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .sh_en     (sh_en),
        .sh_rxd    (sh_rxd),
        .rd_latch  (rd_latch),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sh_en) begin
            q_bits.push_back(sh_rxd);
            q_t.push_back(cyc);
        end
        if (rd_latch) n_latch <= n_latch + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_body(input logic [7:0] b);
        rxd = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BD);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_body(b);
        rxd = stop;
        tick(BD);
    endtask

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++)
            if (base + i < q_bits.size()) v[i] = q_bits[base + i];
        return v;
    endfunction

    function automatic int bad_gaps(input int base);
        int n;
        n = 0;
        for (int i = 1; i < 8; i++)
            if (base + i >= q_t.size() || q_t[base + i] - q_t[base + i - 1] != BD) n++;
        return n;
    endfunction

    task automatic ack_byte();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    initial begin
        int  b0, l0, b1;
        bit  got;

        rst = 1'b1; rxd = 1'b1; rx_ack = 1'b0; err_clr = 1'b0;
        tick(3);
        check("reset_outputs", {sh_en, sh_rxd, rd_latch, rx_valid, frame_err, overrun, busy}, 7'b0);
        rst = 1'b0;
        tick(4);
        check("idle_busy", busy, 1'b0);

        // Normal frame 0xA5
        b0 = q_bits.size(); l0 = n_latch;
        send_byte(8'hA5, 1'b1);
        tick(4);
        check("a5_pulses", q_bits.size() - b0, 8);
        check("a5_bits", byte_at(b0), 8'hA5);
        check("a5_spacing", bad_gaps(b0), 0);
        check("a5_latch", n_latch - l0, 1);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_ferr", frame_err, 1'b0);
        tick(10);
        check("a5_valid_hold", rx_valid, 1'b1);
        ack_byte();
        check("a5_valid_clr", rx_valid, 1'b0);

        // Start glitch
        b0 = q_bits.size(); l0 = n_latch;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(2);
        check("glitch_busy_start", busy, 1'b1);
        tick(5);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_no_sh", q_bits.size() - b0, 0);
        check("glitch_no_latch", n_latch - l0, 0);

        // Framing error and break
        b0 = q_bits.size(); l0 = n_latch;
        send_byte(8'h3C, 1'b0);
        tick(20);
        check("ferr_pulses", q_bits.size() - b0, 8);
        check("ferr_bits", byte_at(b0), 8'h3C);
        check("ferr_no_latch", n_latch - l0, 0);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_break_busy", busy, 1'b1);
        rxd = 1'b1;
        tick(8);
        check("ferr_break_exit", busy, 1'b0);
        b0 = q_bits.size(); l0 = n_latch;
        send_byte(8'h55, 1'b1);
        tick(4);
        check("after_ferr_bits", byte_at(b0), 8'h55);
        check("after_ferr_latch", n_latch - l0, 1);
        check("ferr_sticky", frame_err, 1'b1);
        ack_byte();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ferr_clear", frame_err, 1'b0);

        // Overrun: two frames without ack
        l0 = n_latch;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(4);
        check("ovr_latch", n_latch - l0, 2);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid", rx_valid, 1'b1);
        ack_byte();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr_clear", overrun, 1'b0);
        check("ovr_valid_clr", rx_valid, 1'b0);

        // Ack coincident with second rd_latch
        send_byte(8'h11, 1'b1);
        tick(4);
        check("coinc_first_valid", rx_valid, 1'b1);
        send_body(8'h22);
        rxd = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            if (rd_latch) got = 1'b1;
        end
        check("coinc_latch_seen", got, 1'b1);
        ack_byte();
        check("coinc_no_overrun", overrun, 1'b0);
        check("coinc_valid", rx_valid, 1'b1);
        ack_byte();
        check("coinc_valid_clr", rx_valid, 1'b0);

        // Reset mid-frame after 4 data bits
        b0 = q_bits.size(); l0 = n_latch;
        rxd = 1'b0;
        tick(BD);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0] ? 1'b0 : 1'b1;
            tick(BD);
        end
        check("rst_mid_pulses", q_bits.size() - b0, 4);
        rst = 1'b1; rxd = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_outputs", {sh_en, sh_rxd, rd_latch, rx_valid, frame_err, overrun, busy}, 7'b0);
        tick(40);
        check("rst_mid_no_more_sh", q_bits.size() - b0, 4);
        check("rst_mid_no_latch", n_latch - l0, 0);
        b1 = q_bits.size();
        send_byte(8'hF0, 1'b1);
        tick(4);
        check("post_rst_bits", byte_at(b1), 8'hF0);
        check("post_rst_latch", n_latch - l0, 1);
        ack_byte();

        // Minimum inter-frame gap
        b0 = q_bits.size(); l0 = n_latch;
        send_byte(8'h81, 1'b1);
        send_byte(8'h7E, 1'b1);
        tick(4);
        check("b2b_pulses", q_bits.size() - b0, 16);
        check("b2b_latch", n_latch - l0, 2);
        check("b2b_first", byte_at(b0), 8'h81);
        check("b2b_second", byte_at(b0 + 8), 8'h7E);
        check("b2b_spacing", bad_gaps(b0) + bad_gaps(b0 + 8), 0);
        check("b2b_valid", rx_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
